// File: rtl/nonce_scheduler_pkg.sv
// Shared definitions for the nonce scheduler.
//   DefNumNonces / DefNumCores : default job size and hash-core count
//   word_t                     : 32-bit data word (nonces, hash results)
//   addr_t                     : 16-bit result-memory word address
//   state_e                    : scheduler FSM states
package nonce_scheduler_pkg;

    localparam int unsigned DefNumNonces = 16;
    localparam int unsigned DefNumCores  = 4;
    localparam int unsigned AddrW        = 16;

    typedef logic [31:0]      word_t;
    typedef logic [AddrW-1:0] addr_t;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRun    = 2'd1,
        StFinish = 2'd2
    } state_e;

endpackage

// File: rtl/nonce_scheduler_if.sv
// Bundle of job-control, hash-core and result-memory signals of the scheduler.
//   slave  : scheduler side (consumes start/output_addr/core_done/core_h0)
//   master : environment side (job requester, hash cores, result memory)
interface nonce_scheduler_if #(
    parameter int unsigned NUM_CORES = nonce_scheduler_pkg::DefNumCores
) ();
    import nonce_scheduler_pkg::*;

    logic                         start;
    addr_t                        output_addr;
    logic                         done;
    logic  [NUM_CORES-1:0]        core_start;
    word_t                        core_nonce;
    logic  [NUM_CORES-1:0]        core_done;
    word_t [NUM_CORES-1:0]        core_h0;
    logic                         mem_we;
    addr_t                        mem_addr;
    word_t                        mem_write_data;

    modport slave (
        input  start, output_addr, core_done, core_h0,
        output done, core_start, core_nonce, mem_we, mem_addr, mem_write_data
    );

    modport master (
        output start, output_addr, core_done, core_h0,
        input  done, core_start, core_nonce, mem_we, mem_addr, mem_write_data
    );

endinterface

// File: rtl/nonce_scheduler_prio_enc.sv
// Lowest-set-bit priority encoder.
//   req_i   : request vector
//   idx_o   : index of the lowest set bit (0 when none set)
//   valid_o : at least one request bit is set
module nonce_scheduler_prio_enc #(
    parameter int unsigned Width = 4,
    parameter int unsigned IdxW  = (Width > 1) ? $clog2(Width) : 1
) (
    input  logic [Width-1:0] req_i,
    output logic [IdxW-1:0]  idx_o,
    output logic             valid_o
);

    // Scan from the top down so the lowest set bit wins.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = int'(Width) - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o   = IdxW'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nonce_scheduler.sv
// Nonce scheduler: hands out nonces 0..NUM_NONCES-1 to NUM_CORES hash cores, collects
// each core's H0 and writes it to output_addr + nonce, then pulses done.
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : slave side of nonce_scheduler_if (job control, core launch/result,
//             memory write port)
module nonce_scheduler
    import nonce_scheduler_pkg::*;
#(
    parameter int unsigned NUM_NONCES = DefNumNonces,
    parameter int unsigned NUM_CORES  = DefNumCores
) (
    input logic              clk,
    input logic              reset_n,
    nonce_scheduler_if.slave bus
);

    localparam int unsigned CntW = $clog2(NUM_NONCES + 1);
    localparam int unsigned IdxW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    state_e                state_q, state_d;
    logic [CntW-1:0]       next_nonce_q, next_nonce_d;
    logic [CntW-1:0]       write_count_q, write_count_d;
    logic [NUM_CORES-1:0]  busy_q, busy_d;
    logic [NUM_CORES-1:0]  pending_q, pending_d;
    word_t                 nonce_q  [NUM_CORES];
    word_t                 result_q [NUM_CORES];

    logic [IdxW-1:0]       disp_idx, wb_idx;
    logic                  idle_any, pend_any;
    logic                  dispatch, write_back;
    logic [NUM_CORES-1:0]  accept;

    nonce_scheduler_prio_enc #(
        .Width (NUM_CORES),
        .IdxW  (IdxW)
    ) u_idle_sel (
        .req_i   (~busy_q),
        .idx_o   (disp_idx),
        .valid_o (idle_any)
    );

    nonce_scheduler_prio_enc #(
        .Width (NUM_CORES),
        .IdxW  (IdxW)
    ) u_pend_sel (
        .req_i   (pending_q),
        .idx_o   (wb_idx),
        .valid_o (pend_any)
    );

    assign dispatch   = (state_q == StRun) && idle_any && (next_nonce_q < CntW'(NUM_NONCES));
    assign write_back = (state_q == StRun) && pend_any;
    // Only a core that is running (busy, result not yet held) may deliver a result.
    assign accept     = (state_q == StRun) ? (bus.core_done & busy_q & ~pending_q) : '0;

    always_comb begin
        state_d       = state_q;
        next_nonce_d  = next_nonce_q;
        write_count_d = write_count_q;
        busy_d        = busy_q;
        pending_d     = pending_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d       = StRun;
                    next_nonce_d  = '0;
                    write_count_d = '0;
                    busy_d        = '0;
                    pending_d     = '0;
                end
            end
            StRun: begin
                pending_d = pending_q | accept;
                if (dispatch) begin
                    busy_d[disp_idx] = 1'b1;
                    next_nonce_d     = next_nonce_q + 1'b1;
                end
                if (write_back) begin
                    busy_d[wb_idx]    = 1'b0;
                    pending_d[wb_idx] = 1'b0;
                    write_count_d     = write_count_q + 1'b1;
                    if (write_count_q == CntW'(NUM_NONCES - 1)) begin
                        state_d = StFinish;
                    end
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Outputs decode registered state only, so they are glitch-free relative to inputs
    // (apart from output_addr, which is a static job parameter).
    always_comb begin
        bus.core_start     = '0;
        bus.core_nonce     = '0;
        bus.mem_we         = 1'b0;
        bus.mem_addr       = '0;
        bus.mem_write_data = '0;
        if (dispatch) begin
            bus.core_start[disp_idx] = 1'b1;
            bus.core_nonce           = 32'(next_nonce_q);
        end
        if (write_back) begin
            bus.mem_we         = 1'b1;
            bus.mem_addr       = addr_t'(32'(bus.output_addr) + nonce_q[wb_idx]);
            bus.mem_write_data = result_q[wb_idx];
        end
    end

    assign bus.done = (state_q == StFinish);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            next_nonce_q  <= '0;
            write_count_q <= '0;
            busy_q        <= '0;
            pending_q     <= '0;
            for (int i = 0; i < int'(NUM_CORES); i++) begin
                nonce_q[i]  <= '0;
                result_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            next_nonce_q  <= next_nonce_d;
            write_count_q <= write_count_d;
            busy_q        <= busy_d;
            pending_q     <= pending_d;
            if (dispatch) begin
                nonce_q[disp_idx] <= 32'(next_nonce_q);
            end
            for (int i = 0; i < int'(NUM_CORES); i++) begin
                if (accept[i]) begin
                    result_q[i] <= bus.core_h0[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_nonce_scheduler.sv
module tb_nonce_scheduler;
    import nonce_scheduler_pkg::*;

    localparam int unsigned NA   = 16;
    localparam int unsigned NB   = 3;
    localparam int unsigned NC   = 4;
    localparam word_t       Salt = 32'hA5A5A5A5;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    nonce_scheduler_if #(.NUM_CORES(NC)) a_if ();
    nonce_scheduler_if #(.NUM_CORES(NC)) b_if ();

    nonce_scheduler #(.NUM_NONCES(NA), .NUM_CORES(NC)) u_dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (a_if)
    );

    nonce_scheduler #(.NUM_NONCES(NB), .NUM_CORES(NC)) u_dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (b_if)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // Scoreboard: expected memory writes, pushed when a core model reports a result.
    typedef struct packed {
        addr_t addr;
        word_t data;
    } wr_t;
    wr_t exp_q[$];

    addr_t base = '0;
    int    mode = 0;      // 0: latency 10, 1: cores release together, 2: random latency
    bit    spur = 1'b0;   // inject core_done on cores with no running job
    int    cyc = 0;
    int    a_writes = 0;
    int    a_done = 0;
    int    a_launch = 0;
    int    first_cyc = 0;
    bit    hold [NC];
    int    core_of [NA];
    bit    b_fin = 1'b0;

    // Hash-core model for DUT A: H0 = nonce ^ A5A5A5A5 after a per-launch latency.
    initial begin
        int    tmr [NC];
        word_t jn  [NC];
        bit    wt  [NC];
        bit    counting;
        a_if.core_done = '0;
        a_if.core_h0   = '0;
        for (int i = 0; i < int'(NC); i++) begin
            tmr[i] = 0;
            jn[i]  = '0;
            wt[i]  = 1'b0;
        end
        forever begin
            @(negedge clk);
            a_if.core_done = '0;
            if (!reset_n) begin
                for (int i = 0; i < int'(NC); i++) begin
                    tmr[i] = 0;
                    wt[i]  = 1'b0;
                end
            end else begin
                for (int i = 0; i < int'(NC); i++) begin
                    if (tmr[i] > 0) begin
                        tmr[i]--;
                        if (tmr[i] == 0) wt[i] = 1'b1;
                    end
                end
                for (int i = 0; i < int'(NC); i++) begin
                    if (a_if.core_start[i]) begin
                        jn[i]  = a_if.core_nonce;
                        tmr[i] = (mode == 0) ? 10 :
                                 (mode == 1) ? int'($urandom_range(12, 3)) :
                                               int'($urandom_range(8, 1));
                    end
                end
                counting = 1'b0;
                for (int i = 0; i < int'(NC); i++) begin
                    if (tmr[i] > 0) counting = 1'b1;
                end
                for (int i = 0; i < int'(NC); i++) begin
                    if (wt[i] && (mode != 1 || !counting)) begin
                        wt[i]             = 1'b0;
                        a_if.core_done[i] = 1'b1;
                        a_if.core_h0[i]   = jn[i] ^ Salt;
                        exp_q.push_back('{addr: base + jn[i][15:0], data: jn[i] ^ Salt});
                    end else if (spur && tmr[i] == 0 && !wt[i] && $urandom_range(3, 0) == 0) begin
                        a_if.core_done[i] = 1'b1;
                        a_if.core_h0[i]   = $urandom;
                    end
                end
            end
        end
    end

    // Monitor for DUT A: launch legality, write-back against scoreboard, done pulses.
    initial begin
        int    idx;
        addr_t nn;
        for (int i = 0; i < int'(NC); i++) hold[i] = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset_n) begin
                for (int i = 0; i < int'(NC); i++) hold[i] = 1'b0;
            end else begin
                if (a_if.core_start != '0) begin
                    chk("launch_onehot", 64'($countones(a_if.core_start)), 64'd1);
                    for (int i = 0; i < int'(NC); i++) begin
                        if (a_if.core_start[i]) begin
                            chk("launch_nonce", 64'(a_if.core_nonce), 64'(a_launch));
                            chk("launch_core_free", 64'(hold[i]), 64'd0);
                            hold[i] = 1'b1;
                            if (a_if.core_nonce < NA) core_of[a_if.core_nonce] = i;
                        end
                    end
                    a_launch++;
                end
                if (a_if.mem_we) begin
                    idx = -1;
                    foreach (exp_q[k]) begin
                        if (idx < 0 && exp_q[k].addr == a_if.mem_addr) idx = k;
                    end
                    chk("write_expected", 64'(idx >= 0), 64'd1);
                    if (idx >= 0) begin
                        chk("write_data", 64'(a_if.mem_write_data), 64'(exp_q[idx].data));
                        nn = a_if.mem_addr - base;
                        hold[core_of[nn]] = 1'b0;
                        exp_q.delete(idx);
                    end
                    if (mode == 1 && a_writes < 4) begin
                        chk("sync_order_addr", 64'(a_if.mem_addr), 64'(base + 16'(a_writes)));
                        if (a_writes == 0) first_cyc = cyc;
                        else chk("sync_order_cycle", 64'(cyc), 64'(first_cyc + a_writes));
                    end
                    a_writes++;
                end
                if (a_if.done) a_done++;
            end
        end
    end

    // DUT B: three nonces on four cores; core 3 must stay unused.
    initial begin
        int    bt [NC];
        int    b_wr, b_dn, b_c3;
        bit    seen [NB];
        addr_t off;
        b_if.start       = 1'b0;
        b_if.output_addr = 16'h0300;
        b_if.core_done   = '0;
        b_if.core_h0     = '0;
        b_wr = 0;
        b_dn = 0;
        b_c3 = 0;
        for (int i = 0; i < int'(NC); i++) bt[i] = 0;
        for (int k = 0; k < int'(NB); k++) seen[k] = 1'b0;
        wait (reset_n);
        for (int it = 0; it < 120; it++) begin
            @(negedge clk);
            b_if.start     = (it == 1);
            b_if.core_done = '0;
            for (int i = 0; i < int'(NC); i++) begin
                if (bt[i] > 0) begin
                    bt[i]--;
                    if (bt[i] == 0) b_if.core_done[i] = 1'b1;
                end
            end
            for (int i = 0; i < int'(NC); i++) begin
                if (b_if.core_start[i]) begin
                    b_if.core_h0[i] = b_if.core_nonce ^ Salt;
                    bt[i] = 4;
                    if (i == 3) b_c3++;
                end
            end
            if (b_if.mem_we) begin
                off = b_if.mem_addr - 16'h0300;
                chk("b_write_addr_range", 64'(off < NB), 64'd1);
                chk("b_write_data", 64'(b_if.mem_write_data), 64'(32'(off) ^ Salt));
                if (off < NB) seen[off] = 1'b1;
                b_wr++;
            end
            if (b_if.done) b_dn++;
        end
        chk("b_core3_never_started", 64'(b_c3), 64'd0);
        chk("b_write_count", 64'(b_wr), 64'(NB));
        chk("b_done_once", 64'(b_dn), 64'd1);
        for (int k = 0; k < int'(NB); k++) chk("b_addr_written", 64'(seen[k]), 64'd1);
        b_fin = 1'b1;
    end

    task automatic pulse_start(input addr_t b, input int m, input bit sp);
        base     = b;
        mode     = m;
        spur     = sp;
        a_writes = 0;
        a_done   = 0;
        a_launch = 0;
        a_if.output_addr = b;
        @(negedge clk); #1;
        a_if.start = 1'b1;
        @(negedge clk); #1;
        a_if.start = 1'b0;
        chk("first_launch_core", 64'(a_if.core_start), 64'd1);
        chk("first_launch_nonce", 64'(a_if.core_nonce), 64'd0);
    endtask

    task automatic run_job(input addr_t b, input int m, input bit sp, input bit poke);
        int guard;
        pulse_start(b, m, sp);
        guard = 0;
        while (a_done == 0 && guard < 2000) begin
            @(negedge clk); #1;
            guard++;
            a_if.start = poke && (guard == 20);
        end
        a_if.start = 1'b0;
        chk("job_done_seen", 64'(a_done), 64'd1);
        repeat (20) @(negedge clk);
        #1;
        chk("write_total", 64'(a_writes), 64'(NA));
        chk("launch_total", 64'(a_launch), 64'(NA));
        chk("done_once", 64'(a_done), 64'd1);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_done"}, 64'(a_if.done), 64'd0);
        chk({tag, "_mem_we"}, 64'(a_if.mem_we), 64'd0);
        chk({tag, "_mem_addr"}, 64'(a_if.mem_addr), 64'd0);
        chk({tag, "_mem_data"}, 64'(a_if.mem_write_data), 64'd0);
        chk({tag, "_core_start"}, 64'(a_if.core_start), 64'd0);
        chk({tag, "_core_nonce"}, 64'(a_if.core_nonce), 64'd0);
    endtask

    initial begin
        int guard;
        a_if.start       = 1'b0;
        a_if.output_addr = '0;
        #12;
        chk_outputs_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        run_job(16'h0100, 0, 1'b0, 1'b0);
        run_job(16'($urandom), 1, 1'b0, 1'b0);
        run_job(16'hFFFE, 2, 1'b1, 1'b1);

        wait (b_fin);
        pulse_start(16'h0200, 0, 1'b0);
        guard = 0;
        while (a_writes < 5 && guard < 500) begin
            @(negedge clk); #1;
            guard++;
        end
        chk("pre_reset_writes", 64'(a_writes), 64'd5);
        #2;
        reset_n = 1'b0;
        #1;
        chk_outputs_zero("midjob_reset");
        repeat (3) @(negedge clk);
        #1;
        chk("abort_no_done", 64'(a_done), 64'd0);
        exp_q.delete();
        reset_n = 1'b1;
        run_job(16'h0200, 0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

endmodule
